// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared definitions for the load/store control stage.
//   lsu_state_e    : controller state encoding
//   F3_* constants : RISC-V load/store width codes (funct3)
//   MASK_* consts  : byte-strobe bases before lane shifting
//   lsu_misaligned : alignment check on funct3 width and addr[1:0]
package ysyx_23060240_lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_ST   = 3'd3,
      S_OUT  = 3'd4
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
   function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return (addr_lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_align.sv
// Combinational lane alignment for loads and stores.
//   funct3     : width/sign code
//   addr_lo    : byte offset within the word
//   rdata      : raw read word from the bus
//   wdata_in   : low-aligned store data
//   load_data  : shifted and sign/zero-extended load result
//   store_data : store data moved to its byte lane
//   store_mask : 4-bit byte strobes for the store
module ysyx_23060240_lsu_align
   import ysyx_23060240_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata_in,
   output logic [31:0] load_data,
   output logic [31:0] store_data,
   output logic [3:0]  store_mask
);

   logic [4:0]  lane_shift;
   logic [31:0] rshift;

   assign lane_shift = {addr_lo, 3'b000};
   assign rshift     = rdata >> lane_shift;
   assign store_data = wdata_in << lane_shift;

   always_comb begin
      load_data = rshift;
      case (funct3)
         F3_LB:   load_data = {{24{rshift[7]}}, rshift[7:0]};
         F3_LH:   load_data = {{16{rshift[15]}}, rshift[15:0]};
         F3_LW:   load_data = rshift;
         F3_LBU:  load_data = {24'd0, rshift[7:0]};
         F3_LHU:  load_data = {16'd0, rshift[15:0]};
         default: load_data = rshift;
      endcase
   end

   always_comb begin
      store_mask = MASK_W << addr_lo;
      case (funct3[1:0])
         F3_SB[1:0]: store_mask = MASK_B << addr_lo;
         F3_SH[1:0]: store_mask = MASK_H << addr_lo;
         default:    store_mask = MASK_W << addr_lo;
      endcase
   end

endmodule

// File: rtl/ysyx_23060240_lsu_ctrl.sv
// Load/store control stage between EXU and the SRAM_LSU slave.
//   clk, rst            : clock, synchronous active-high reset
//   in_*                : operation from EXU (valid/ready)
//   maxi_ar*, maxi_r*   : AXI-lite read address / read data channels
//   waddr/wdata/wmask   : store port, qualified by the one-cycle w_en
//   out_*               : result to WBU (valid/ready), held stable in OUT
//
// state | meaning
// IDLE  | ready for a new operation, araddr parked at RESET_ADDR
// AR    | read address presented, waiting for arready
// R     | waiting for read data
// ST    | store strobe asserted for this single cycle
// OUT   | result presented to WBU, waiting for out_ready
module ysyx_23060240_lsu_ctrl
   import ysyx_23060240_lsu_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [4:0]  in_rd,
   output logic [31:0] maxi_araddr,
   output logic        maxi_arvalid,
   input  logic        maxi_arready,
   input  logic [31:0] maxi_rdata,
   input  logic        maxi_rvalid,
   output logic        maxi_rready,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic [7:0]  wmask,
   output logic        w_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_is_load,
   output logic        out_err
);

   lsu_state_e  state, state_n;
   logic [31:0] addr_q;
   logic [2:0]  funct3_q;

   logic        accept;
   logic        acc_err;
   logic [2:0]  al_funct3;
   logic [1:0]  al_addr_lo;
   logic [31:0] al_load_data;
   logic [31:0] al_store_data;
   logic [3:0]  al_store_mask;

   assign accept  = in_valid && (state == S_IDLE);
   assign acc_err = (in_is_load || in_is_store) &&
                    lsu_misaligned(in_funct3, in_addr[1:0]);

   // One aligner serves both directions: in IDLE it shapes the incoming
   // store, afterwards it extends read data for the latched operation.
   assign al_funct3  = (state == S_IDLE) ? in_funct3 : funct3_q;
   assign al_addr_lo = (state == S_IDLE) ? in_addr[1:0] : addr_q[1:0];

   ysyx_23060240_lsu_align u_align (
      .funct3     (al_funct3),
      .addr_lo    (al_addr_lo),
      .rdata      (maxi_rdata),
      .wdata_in   (in_wdata),
      .load_data  (al_load_data),
      .store_data (al_store_data),
      .store_mask (al_store_mask)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               if (acc_err)          state_n = S_OUT;
               else if (in_is_load)  state_n = S_AR;
               else if (in_is_store) state_n = S_ST;
               else                  state_n = S_OUT;
            end
         end
         S_AR:    if (maxi_arready) state_n = S_R;
         S_R:     if (maxi_rvalid)  state_n = S_OUT;
         S_ST:    state_n = S_OUT;
         S_OUT:   if (out_ready)    state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         funct3_q    <= '0;
         out_rd      <= '0;
         out_is_load <= 1'b0;
         out_err     <= 1'b0;
         out_rdata   <= '0;
         waddr       <= '0;
         wdata       <= '0;
         wmask       <= '0;
      end else begin
         if (accept) begin
            addr_q      <= in_addr;
            funct3_q    <= in_funct3;
            out_rd      <= in_rd;
            out_is_load <= in_is_load;
            out_err     <= acc_err;
            out_rdata   <= '0;
            if (in_is_store && !in_is_load && !acc_err) begin
               waddr <= {in_addr[31:2], 2'b00};
               wdata <= al_store_data;
               wmask <= {4'b0000, al_store_mask};
            end
         end
         if ((state == S_R) && maxi_rvalid) begin
            out_rdata <= al_load_data;
         end
      end
   end

   assign in_ready     = (state == S_IDLE);
   assign maxi_arvalid = (state == S_AR);
   assign maxi_araddr  = (state == S_AR) ? {addr_q[31:2], 2'b00} : RESET_ADDR;
   assign maxi_rready  = (state == S_R);
   // Masked by rst so a reset landing on the store cycle suppresses the write.
   assign w_en         = (state == S_ST) && !rst;
   assign out_valid    = (state == S_OUT);

endmodule

// File: tb/tb_ysyx_23060240_lsu_ctrl.sv
module tb_ysyx_23060240_lsu_ctrl;

   localparam logic [31:0] RESET_ADDR = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_addr = '0;
   logic [31:0] in_wdata = '0;
   logic        in_is_load = 1'b0;
   logic        in_is_store = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [4:0]  in_rd = '0;
   logic [31:0] maxi_araddr;
   logic        maxi_arvalid;
   logic        maxi_arready = 1'b1;
   logic [31:0] maxi_rdata = '0;
   logic        maxi_rvalid = 1'b0;
   logic        maxi_rready;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [7:0]  wmask;
   logic        w_en;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_rdata;
   logic [4:0]  out_rd;
   logic        out_is_load;
   logic        out_err;

   ysyx_23060240_lsu_ctrl #(.RESET_ADDR(RESET_ADDR)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_rd(in_rd),
      .maxi_araddr(maxi_araddr), .maxi_arvalid(maxi_arvalid), .maxi_arready(maxi_arready),
      .maxi_rdata(maxi_rdata), .maxi_rvalid(maxi_rvalid), .maxi_rready(maxi_rready),
      .waddr(waddr), .wdata(wdata), .wmask(wmask), .w_en(w_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_rd(out_rd), .out_is_load(out_is_load), .out_err(out_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_ev(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=event required=none t=%0t", name, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        is_load;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  mask;
   } st_t;

   exp_t        exp_q[$];
   st_t         st_q[$];
   logic [31:0] ar_q[$];
   logic [31:0] slv_q[$];

   function automatic int access_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b01) return 2;
      if (f3[1:0] == 2'b10) return 4;
      return 1;
   endfunction

   function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
      return (addr % access_size(f3)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
      logic [31:0] s, b, h;
      s = word >> (8 * (addr % 4));
      b = s % 256;
      h = s % 65536;
      case (f3)
         3'd0:    return (b >= 128)   ? b - 32'd256   : b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return s;
      endcase
   endfunction

   function automatic st_t model_store(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wd);
      st_t r;
      logic [31:0] m;
      m = ((32'd1 << access_size(f3)) - 32'd1) << (addr % 4);
      r.addr = addr - (addr % 4);
      r.data = wd << (8 * (addr % 4));
      r.mask = m[7:0];
      return r;
   endfunction

   // ---------------- slave and out_ready drivers ----------------
   int   slv_mode = 0;   // 0 immediate, 1 random, 2 arready manual
   int   or_mode  = 0;   // 0 always ready, 1 random, 2 manual
   logic hold_r = 1'b0;
   logic slave_flush = 1'b0;

   initial begin
      logic pending, real_v, ar_hs, r_hs;
      pending = 1'b0;
      real_v  = 1'b0;
      forever begin
         @(negedge clk);
         ar_hs = maxi_arvalid && maxi_arready;
         r_hs  = maxi_rvalid && maxi_rready;
         @(posedge clk);
         #1;
         if (slave_flush) begin
            pending = 1'b0;
            real_v = 1'b0;
            maxi_rvalid = 1'b0;
            slv_q.delete();
            slave_flush = 1'b0;
         end
         if (r_hs) begin
            pending = 1'b0;
            real_v = 1'b0;
         end
         if (ar_hs) pending = 1'b1;
         if (slv_mode == 0) maxi_arready = 1'b1;
         else if (slv_mode == 1) maxi_arready = ($urandom % 3) != 0;
         if (pending) begin
            if (!real_v) begin
               if (!hold_r && (slv_mode != 1 || ($urandom % 2) == 0) && slv_q.size() != 0) begin
                  maxi_rdata  = slv_q.pop_front();
                  maxi_rvalid = 1'b1;
                  real_v = 1'b1;
               end else begin
                  maxi_rvalid = 1'b0;
                  maxi_rdata  = $urandom;
               end
            end
         end else begin
            // stray read data outside a read must be ignored by the DUT
            maxi_rvalid = (slv_mode == 1) && (($urandom % 6) == 0);
            maxi_rdata  = $urandom;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (or_mode == 0) out_ready = 1'b1;
      else if (or_mode == 1) out_ready = ($urandom % 3) != 0;
   end

   // ---------------- monitor ----------------
   initial begin
      logic prev_wen, holding;
      exp_t snap;
      st_t  s;
      prev_wen = 1'b0;
      holding  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wen = 1'b0;
            holding = 1'b0;
         end else begin
            if (in_ready) chk("araddr_idle", maxi_araddr, RESET_ADDR);
            if (maxi_arvalid) begin
               if (ar_q.size() == 0) fail_ev("unexpected_arvalid");
               else begin
                  chk("araddr", maxi_araddr, ar_q[0]);
                  if (maxi_arready) void'(ar_q.pop_front());
               end
            end
            if (w_en) begin
               if (prev_wen) fail_ev("w_en_longer_than_one_cycle");
               if (st_q.size() == 0) fail_ev("unexpected_w_en");
               else begin
                  s = st_q.pop_front();
                  chk("waddr", waddr, s.addr);
                  chk("wdata", wdata, s.data);
                  chk("wmask", 32'(wmask), 32'(s.mask));
               end
            end
            prev_wen = w_en;
            if (out_valid) begin
               if (exp_q.size() == 0) fail_ev("unexpected_out_valid");
               else begin
                  if (!holding) begin
                     chk("out_rdata", out_rdata, exp_q[0].rdata);
                     chk("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
                     chk("out_is_load", 32'(out_is_load), 32'(exp_q[0].is_load));
                     chk("out_err", 32'(out_err), 32'(exp_q[0].err));
                     snap = exp_q[0];
                     holding = 1'b1;
                  end else begin
                     chk("stall_rdata", out_rdata, snap.rdata);
                     chk("stall_rd", 32'(out_rd), 32'(snap.rd));
                     chk("stall_err", 32'(out_err), 32'(snap.err));
                  end
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     holding = 1'b0;
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic ld,
                        input logic st, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] word, input logic expect_out);
      exp_t e;
      logic err;
      int n;
      err = (ld || st) && model_misaligned(f3, addr);
      e.rd = rd;
      e.is_load = ld;
      e.err = err;
      e.rdata = 32'd0;
      if (!err && ld) begin
         ar_q.push_back(addr - (addr % 4));
         slv_q.push_back(word);
         e.rdata = model_load(f3, addr, word);
      end else if (!err && st) begin
         st_q.push_back(model_store(f3, addr, wd));
      end
      if (expect_out) exp_q.push_back(e);
      in_valid = 1'b1;
      in_addr = addr;
      in_wdata = wd;
      in_is_load = ld;
      in_is_store = st;
      in_funct3 = f3;
      in_rd = rd;
      for (n = 0; n < 500; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (n == 500) fail_ev("accept_timeout");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_addr = $urandom;
      in_wdata = $urandom;
      in_is_load = 1'($urandom);
      in_is_store = 1'($urandom);
      in_funct3 = 3'($urandom);
      in_rd = 5'($urandom);
   endtask

   task automatic check_latency(input string name, input int exp_lat);
      int n;
      for (n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk(name, 32'(n), 32'(exp_lat));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      if (n == 100) fail_ev("out_valid_timeout");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_arvalid", 32'(maxi_arvalid), 32'd0);
      chk("rst_rready", 32'(maxi_rready), 32'd0);
      chk("rst_w_en", 32'(w_en), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_out_is_load", 32'(out_is_load), 32'd0);
      chk("rst_out_rdata", out_rdata, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_waddr", waddr, 32'd0);
      chk("rst_wmask", 32'(wmask), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_araddr", maxi_araddr, RESET_ADDR);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // LB sign extension, minimum load latency
      issue(32'h8000_0003, 32'd0, 1'b1, 1'b0, 3'd0, 5'd1, 32'h80FF_1234, 1'b1);
      check_latency("lat_lb", 3);

      // LHU with slow arready and stalled WBU
      slv_mode = 2;
      or_mode = 2;
      maxi_arready = 1'b0;
      out_ready = 1'b0;
      issue(32'h8000_0002, 32'd0, 1'b1, 1'b0, 3'd5, 5'd2, 32'hBEEF_0000, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      maxi_arready = 1'b1;
      wait_out();
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      slv_mode = 0;
      or_mode = 0;

      // SB into lane 1
      issue(32'h8000_0101, 32'h0000_00AB, 1'b0, 1'b1, 3'd0, 5'd3, 32'd0, 1'b1);
      check_latency("lat_sb", 2);

      // misaligned LW
      issue(32'h8000_0002, 32'd0, 1'b1, 1'b0, 3'd2, 5'd4, 32'd0, 1'b1);
      check_latency("lat_err", 1);

      // non-memory op
      issue(32'h1234_5677, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd2, 5'd7, 32'd0, 1'b1);
      check_latency("lat_nonmem", 1);

      // reset while waiting for read data, then stale rvalid
      hold_r = 1'b1;
      issue(32'h8000_0010, 32'd0, 1'b1, 1'b0, 3'd2, 5'd9, 32'h5555_AAAA, 1'b0);
      begin
         int n;
         for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (maxi_rready) break;
         end
         chk("reach_r_state", 32'(maxi_rready), 32'd1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold_r = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_in_ready", 32'(in_ready), 32'd1);
         chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      end
      slave_flush = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // randomized traffic
      slv_mode = 1;
      or_mode = 1;
      for (int i = 0; i < 300; i++) begin
         int kind;
         logic [31:0] a;
         logic [2:0] f3;
         logic ld, st;
         kind = $urandom % 5;
         ld = (kind <= 1) || (kind == 4 && ($urandom % 2) == 0);
         st = (kind == 2) || (kind == 4 && !ld);
         if (kind == 3) begin
            ld = 1'b0;
            st = ($urandom % 4) == 0;
            ld = st;
         end
         if (ld) begin
            case ($urandom % 5)
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end else begin
            f3 = 3'($urandom % 3);
         end
         if (kind == 3 && !ld) f3 = 3'($urandom);
         a = $urandom;
         if (($urandom % 4) != 0) a = a - (a % access_size(f3));
         issue(a, $urandom, ld, st, f3, 5'($urandom), $urandom, 1'b1);
         repeat ($urandom % 3) @(posedge clk);
         #1;
      end

      begin
         int n;
         for (n = 0; n < 5000; n++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && st_q.size() == 0 && ar_q.size() == 0) break;
         end
         chk("drain_pending", 32'(exp_q.size() + st_q.size() + ar_q.size()), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
